req_split: RTL and testbench

- Demultiplexer for the request-callout protocol: the reverse of the two-into-one request arbiter.
- Accepts one enq stream carrying a payload plus a destination tag, and buffers each request in a per-destination FIFO.
- Drains each FIFO onto its own downstream callout method (outa$a, outb$a) using the ENA/RDY handshake.
- Sits between a single request producer and two independent ReqCallout consumers.

---
 rtl/req_split_pkg.sv | 10 +
 rtl/req_split_if.sv | 30 +++
 rtl/req_split_fifo.sv | 48 ++++
 rtl/req_split.sv | 87 ++++++++
 tb/tb_req_split.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/req_split_pkg.sv
// Shared types and constants for the request splitter.
// The optional REQ_SPLIT_STATS_EN build uses STAT_WIDTH for its counters.
package req_split_pkg;
    typedef logic dest_t;

    localparam dest_t DEST_A = 1'b0;
    localparam dest_t DEST_B = 1'b1;

    localparam int STAT_WIDTH = 16;
endpackage

// File: rtl/req_split_if.sv
// Bundle of the enq method and both downstream callout methods.
// The producer/consumer side uses master; req_split uses slave.
interface req_split_if #(
    parameter int DATA_WIDTH = 1
);
    import req_split_pkg::*;

    logic                  enq__ENA;
    logic [DATA_WIDTH-1:0] enq_v;
    dest_t                 enq_dest;
    logic                  enq__RDY;

    logic                  outa_a__ENA;
    logic [DATA_WIDTH-1:0] outa_a_v;
    logic                  outa_a__RDY;

    logic                  outb_a__ENA;
    logic [DATA_WIDTH-1:0] outb_a_v;
    logic                  outb_a__RDY;

    modport master (
        output enq__ENA, enq_v, enq_dest, outa_a__RDY, outb_a__RDY,
        input  enq__RDY, outa_a__ENA, outa_a_v, outb_a__ENA, outb_a_v
    );

    modport slave (
        input  enq__ENA, enq_v, enq_dest, outa_a__RDY, outb_a__RDY,
        output enq__RDY, outa_a__ENA, outa_a_v, outb_a__ENA, outb_a_v
    );
endinterface

// File: rtl/req_split_fifo.sv
// Per-destination synchronous FIFO; head is read combinationally from the
// current read pointer so a pushed entry is visible the cycle after the push.
module req_split_fifo #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [AW:0]           count_q;

    // Pointers wrap naturally modulo DEPTH; the extra count bit separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign head  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_CNT);
endmodule

// File: rtl/req_split.sv
// Splits one enq stream into two buffered ReqCallout streams by dest tag.
// Define REQ_SPLIT_STATS_EN to add saturating delivery/stall counters.
module req_split
    import req_split_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    req_split_if.slave            bus
`ifdef REQ_SPLIT_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0] statA,
    output logic [STAT_WIDTH-1:0] statB,
    output logic [STAT_WIDTH-1:0] statFullStall
`endif
);
    logic                  rdy_q;
    logic                  enq_rdy;
    logic                  sink_rdy [2];
    logic                  push     [2];
    logic                  pop      [2];
    logic                  empty    [2];
    logic                  full     [2];
    logic [DATA_WIDTH-1:0] head     [2];
    logic [DATA_WIDTH-1:0] out_v    [2];

    // Holds enq__RDY low until the first edge after reset release.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) rdy_q <= 1'b0;
        else       rdy_q <= 1'b1;
    end

    // The guard ignores dest: a full side stalls every request.
    assign enq_rdy     = rdy_q && !full[DEST_A] && !full[DEST_B];
    assign sink_rdy[0] = bus.outa_a__RDY;
    assign sink_rdy[1] = bus.outb_a__RDY;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dest
        assign push[gi]  = bus.enq__ENA && enq_rdy && (bus.enq_dest == dest_t'(gi));
        assign pop[gi]   = !empty[gi] && sink_rdy[gi];
        assign out_v[gi] = empty[gi] ? '0 : head[gi];

        req_split_fifo #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH)
        ) u_fifo (
            .clk      (CLK),
            .rst_n    (nRST),
            .push     (push[gi]),
            .push_data(bus.enq_v),
            .pop      (pop[gi]),
            .head     (head[gi]),
            .empty    (empty[gi]),
            .full     (full[gi])
        );
    end

    assign bus.enq__RDY    = enq_rdy;
    assign bus.outa_a__ENA = pop[DEST_A];
    assign bus.outa_a_v    = out_v[DEST_A];
    assign bus.outb_a__ENA = pop[DEST_B];
    assign bus.outb_a_v    = out_v[DEST_B];

`ifdef REQ_SPLIT_STATS_EN
    logic [STAT_WIDTH-1:0] stat_q [2];
    logic [STAT_WIDTH-1:0] stall_q;

    for (genvar gi = 0; gi < 2; gi++) begin : g_stat
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST)                         stat_q[gi] <= '0;
            else if (pop[gi] && !(&stat_q[gi])) stat_q[gi] <= stat_q[gi] + 1'b1;
        end
    end

    // The reset-release cycle is not a stall; only full-induced guard drops count.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                              stall_q <= '0;
        else if (rdy_q && !enq_rdy && !(&stall_q)) stall_q <= stall_q + 1'b1;
    end

    assign statA         = stat_q[DEST_A];
    assign statB         = stat_q[DEST_B];
    assign statFullStall = stall_q;
`endif
endmodule

// File: tb/tb_req_split.sv
// Directed self-checking bench for req_split (DEPTH=4, 8-bit payload).
// Counter checks are included when REQ_SPLIT_STATS_EN is defined.
module tb_req_split;
    import req_split_pkg::*;

    localparam int DW = 8;

    logic clk;
    logic nrst;
    int   n_cmp;
    int   n_err;

    req_split_if #(.DATA_WIDTH(DW)) bus ();

`ifdef REQ_SPLIT_STATS_EN
    logic [STAT_WIDTH-1:0] stat_a, stat_b, stat_stall;
`endif

    req_split #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .CLK (clk),
        .nRST(nrst),
        .bus (bus.slave)
`ifdef REQ_SPLIT_STATS_EN
        ,
        .statA        (stat_a),
        .statB        (stat_b),
        .statFullStall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [DW-1:0] v, input dest_t d);
        bus.enq__ENA = 1'b1;
        bus.enq_v    = v;
        bus.enq_dest = d;
        step();
        bus.enq__ENA = 1'b0;
        #1;
    endtask

    // An ENA must never appear without its downstream RDY.
    always @(negedge clk) begin
        if (nrst && (bus.outa_a__ENA || bus.outb_a__ENA)) begin
            chk("ena_a_needs_rdy", {31'd0, bus.outa_a__ENA & ~bus.outa_a__RDY}, 32'd0);
            chk("ena_b_needs_rdy", {31'd0, bus.outb_a__ENA & ~bus.outb_a__RDY}, 32'd0);
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        nrst  = 1'b0;
        bus.enq__ENA    = 1'b0;
        bus.enq_v       = '0;
        bus.enq_dest    = DEST_A;
        bus.outa_a__RDY = 1'b1;
        bus.outb_a__RDY = 1'b1;

        // Reset state
        step(); step(); #1;
        chk("rst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd0);
        chk("rst_ena_a",   {31'd0, bus.outa_a__ENA}, 32'd0);
        chk("rst_ena_b",   {31'd0, bus.outb_a__ENA}, 32'd0);
        chk("rst_v_a",     {24'd0, bus.outa_a_v}, 32'd0);
        chk("rst_v_b",     {24'd0, bus.outb_a_v}, 32'd0);
        nrst = 1'b1;
        #1;
        chk("release_rdy_before_edge", {31'd0, bus.enq__RDY}, 32'd0);
        step(); #1;
        chk("release_rdy_after_edge", {31'd0, bus.enq__RDY}, 32'd1);

        // Single request to A: visible exactly one cycle later
        bus.enq__ENA = 1'b1; bus.enq_v = 8'h01; bus.enq_dest = DEST_A; #1;
        chk("no_bypass_ena_a", {31'd0, bus.outa_a__ENA}, 32'd0);
        step();
        bus.enq__ENA = 1'b0; #1;
        chk("single_ena_a", {31'd0, bus.outa_a__ENA}, 32'd1);
        chk("single_v_a",   {24'd0, bus.outa_a_v}, 32'h01);
        chk("single_ena_b", {31'd0, bus.outb_a__ENA}, 32'd0);
        step(); #1;
        chk("single_drained_ena_a", {31'd0, bus.outa_a__ENA}, 32'd0);
        chk("single_drained_v_a",   {24'd0, bus.outa_a_v}, 32'h00);

        // Fill B while stalled, then drain in order
        bus.outb_a__RDY = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fillb_rdy_%0d", i), {31'd0, bus.enq__RDY}, 32'd1);
            enq(8'h10 + 8'(i), DEST_B);
        end
        chk("fullb_enq_rdy", {31'd0, bus.enq__RDY}, 32'd0);
        chk("fullb_ena_b",   {31'd0, bus.outb_a__ENA}, 32'd0);
        chk("fullb_head_b",  {24'd0, bus.outb_a_v}, 32'h10);
        bus.outb_a__RDY = 1'b1; #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drainb_ena_%0d", i), {31'd0, bus.outb_a__ENA}, 32'd1);
            chk($sformatf("drainb_v_%0d", i),   {24'd0, bus.outb_a_v}, 32'h10 + 32'(i));
            step(); #1;
            if (i == 0) chk("drainb_rdy_back", {31'd0, bus.enq__RDY}, 32'd1);
        end
        chk("drainb_empty_ena", {31'd0, bus.outb_a__ENA}, 32'd0);

        // Alternate destinations, both sinks ready
        for (int i = 0; i < 8; i++) begin
            bus.enq__ENA = 1'b1;
            bus.enq_v    = 8'h20 + 8'(i);
            bus.enq_dest = dest_t'(i % 2);
            step(); #1;
            if (i % 2 == 0) begin
                chk($sformatf("alt_ena_a_%0d", i), {31'd0, bus.outa_a__ENA}, 32'd1);
                chk($sformatf("alt_v_a_%0d", i),   {24'd0, bus.outa_a_v}, 32'h20 + 32'(i));
                chk($sformatf("alt_idle_b_%0d", i), {31'd0, bus.outb_a__ENA}, 32'd0);
            end else begin
                chk($sformatf("alt_ena_b_%0d", i), {31'd0, bus.outb_a__ENA}, 32'd1);
                chk($sformatf("alt_v_b_%0d", i),   {24'd0, bus.outb_a_v}, 32'h20 + 32'(i));
                chk($sformatf("alt_idle_a_%0d", i), {31'd0, bus.outa_a__ENA}, 32'd0);
            end
        end
        bus.enq__ENA = 1'b0;
        step(); #1;
        chk("alt_done_a", {31'd0, bus.outa_a__ENA}, 32'd0);
        chk("alt_done_b", {31'd0, bus.outb_a__ENA}, 32'd0);

        // A full blocks B requests; B still drains
        bus.outa_a__RDY = 1'b0;
        bus.outb_a__RDY = 1'b0;
        enq(8'h40, DEST_B);
        enq(8'h41, DEST_B);
        for (int i = 0; i < 4; i++) enq(8'h30 + 8'(i), DEST_A);
        chk("hol_enq_rdy", {31'd0, bus.enq__RDY}, 32'd0);
        bus.enq__ENA = 1'b1; bus.enq_v = 8'h55; bus.enq_dest = DEST_B;
        bus.outb_a__RDY = 1'b1; #1;
        chk("hol_b_ena0", {31'd0, bus.outb_a__ENA}, 32'd1);
        chk("hol_b_v0",   {24'd0, bus.outb_a_v}, 32'h40);
        step(); #1;
        chk("hol_b_v1",   {24'd0, bus.outb_a_v}, 32'h41);
        chk("hol_rdy_still0", {31'd0, bus.enq__RDY}, 32'd0);
        step(); #1;
        chk("hol_violation_ignored", {31'd0, bus.outb_a__ENA}, 32'd0);
        bus.enq__ENA = 1'b0;
        chk("hol_a_head", {24'd0, bus.outa_a_v}, 32'h30);
        chk("hol_a_ena",  {31'd0, bus.outa_a__ENA}, 32'd0);

        // Pop one from A, then reset with 3 entries still buffered
        bus.outa_a__RDY = 1'b1;
        step(); #1;
        chk("pre_rst_v_a", {24'd0, bus.outa_a_v}, 32'h31);
        nrst = 1'b0; #1;
        chk("midrst_ena_a",   {31'd0, bus.outa_a__ENA}, 32'd0);
        chk("midrst_v_a",     {24'd0, bus.outa_a_v}, 32'h00);
        chk("midrst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd0);
        step();
        nrst = 1'b1;
        step(); #1;
        chk("postrst_ena_a",   {31'd0, bus.outa_a__ENA}, 32'd0);
        chk("postrst_v_a",     {24'd0, bus.outa_a_v}, 32'h00);
        chk("postrst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd1);
        enq(8'h77, DEST_A);
        chk("postrst_fresh_v", {24'd0, bus.outa_a_v}, 32'h77);
        chk("postrst_fresh_ena", {31'd0, bus.outa_a__ENA}, 32'd1);
        step(); #1;
        chk("postrst_drained", {31'd0, bus.outa_a__ENA}, 32'd0);

`ifdef REQ_SPLIT_STATS_EN
        // Fresh reset: 3 stall cycles, 5 A deliveries, no B deliveries
        nrst = 1'b0; #1;
        chk("stat_rst_a", {16'd0, stat_a}, 32'd0);
        step();
        nrst = 1'b1;
        step(); #1;
        bus.outa_a__RDY = 1'b0;
        for (int i = 0; i < 4; i++) enq(8'h60 + 8'(i), DEST_A);
        step(); step();
        bus.outa_a__RDY = 1'b1;
        for (int i = 0; i < 4; i++) step();
        enq(8'h64, DEST_A);
        step(); #1;
        chk("stat_a",     {16'd0, stat_a}, 32'd5);
        chk("stat_b",     {16'd0, stat_b}, 32'd0);
        chk("stat_stall", {16'd0, stat_stall}, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
